coef_mac38: RTL
===============

# coef_mac38

- Sequential multiply-accumulate stage feeding the pseudo-Mersenne reducer for p = 2^25 − 2^12 + 1 = 33550337.
- Computes c = Σ a_i·b_i over a programmed number of terms (1..32), where a_i is a 25-bit residue and b_i an 8-bit unsigned small coefficient.
- Presents the unreduced 38-bit sum on a valid/ready port that drives the reducer's `c` input directly.
- Bound: 32·(p−1)·255 < 2^38, so the sum never overflows.

## Interface
- `AW`, default 25: width of `a`.
- `BW`, default 8: width of `b`.
- `CW`, default 38: width of the accumulator and of `c`.
- `clk` input, 1 bit: clock, rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a new sum. Sampled only in IDLE.
- `len_m1` input, 5 bits: number of terms minus 1. Captured at start.
- `in_valid` input, 1 bit: term `a`/`b` valid.
- `in_ready` output, 1 bit: block accepts a term.
- `a` input, AW bits: residue operand.
- `b` input, BW bits: small coefficient, unsigned.
- `out_valid` output, 1 bit: `c` valid.
- `out_ready` input, 1 bit: downstream accepts `c`.
- `c` output, CW bits: accumulated sum.
- `busy` output, 1 bit: high in any state other than IDLE.
- `err` output, 1 bit: sticky range error. See Configuration.

## Operation
- **FSM states:** IDLE, ACC, DRAIN, OUT.
- **IDLE:**
  - `start` = 1 at an edge: clear the accumulator, clear `err`, load the remaining-term counter with `len_m1`, go to ACC.
- **ACC:**
  - `in_ready` = 1.
  - Each beat with `in_valid` & `in_ready` registers the product a·b (33 bits) into the product register and flags it valid.
  - The beat that handshakes when the counter is 0 is the last beat: go to DRAIN. Otherwise decrement the counter.
- **Accumulate stage:**
  - Every edge on which the product register is valid adds its zero-extended value to the 38-bit accumulator.
  - Runs in every state, so a product accepted in ACC is summed one edge later.
- **DRAIN:**
  - One cycle, with `in_ready` = 0.
  - Its edge adds the last product, then the FSM goes to OUT.
- **OUT:**
  - `out_valid` = 1 and `c` = accumulator, held stable until `out_valid` & `out_ready`.
  - On that handshake, go to IDLE.
- **Ignored inputs:**
  - `start` outside IDLE has no effect.
  - `in_valid` outside ACC has no effect.
- **Input bubbles:** `in_valid` low in ACC stalls with no state change. The product register's valid flag clears, so nothing is added.
- **Arithmetic:** unsigned only. No modular reduction is done here; the downstream reducer handles it.
- **Reset mid-operation:** all state is discarded and the FSM returns to IDLE. There is no partial output.

## Timing
- **Reset values:** `in_ready` 0, `out_valid` 0, `c` 0, `busy` 0, `err` 0, FSM IDLE.
- **Start:** `start` sampled at edge k ⇒ `in_ready` is high from cycle k+1.
- **Throughput:** one term per cycle with no bubbles. A 32-term sum takes 32 beat cycles.
- **Latency:** last beat at edge k ⇒ DRAIN in cycle k+1 ⇒ `out_valid` high from cycle k+2.
- **Block turnaround:**
  - Output handshake at edge m ⇒ IDLE in cycle m+1, so the next `start` can be sampled at edge m+1.
  - Minimum turnaround: len+3 cycles per block with no backpressure.
- **Handshake rule:** `c` must not change while `out_valid` = 1 and `out_ready` = 0.
- **Combinational paths:** none from `out_ready` or `in_valid` to any output. All outputs come from registers or decode the FSM state.

## Configuration
- **Macro:** `COEF_MAC38_RANGE_CHK_EN`.
- **Defined:**
  - Each accepted beat with a ≥ 33550337 sets `err`.
  - `err` is sticky until the next accepted `start` or reset.
  - The sum is still computed normally.
- **Undefined:** `err` is tied to constant 0 and the comparator is not synthesized.

## Test plan
- **Single term:** `len_m1`=0, a=33550336, b=255 ⇒ `out_valid` two cycles after the beat, c=8555335680, `err`=0.
- **Full-length max:** `len_m1`=31, 32 back-to-back beats of a=33550336, b=255 ⇒ c=273770741760 (no overflow), `out_valid` at cycle 34 after `start`.
- **Bubbles and backpressure:**
  - Stimulus: `len_m1`=3, terms (1,1),(2,3),(4,5),(100,200), `in_valid` toggled every other cycle, `out_ready` held low 5 cycles.
  - Required: c=20027, stable while stalled, single handshake.
- **Ignored inputs:**
  - `start` asserted during ACC and OUT ⇒ no effect.
  - `in_valid` asserted in IDLE ⇒ `in_ready`=0 and the next sum is unaffected.
- **Reset mid-sum:** pulse `rst_n` low after 2 of 4 beats ⇒ all outputs return to reset values. A new `start` with terms (7,9) and `len_m1`=0 ⇒ c=63.
- **Range check:**
  - With the macro defined: beat a=33550337, b=1 ⇒ `err`=1 through OUT, c=33550337; the next `start` clears `err`.
  - Without the macro: `err` stays 0.

Source files
------------

// File: rtl/coef_mac38.sv
// coef_mac38: sequential a*b multiply-accumulate feeding the p = 2^25-2^12+1 reducer.
// Optional input range check on a is enabled by defining COEF_MAC38_RANGE_CHK_EN.
module coef_mac38 #(
  parameter int AW = 25,
  parameter int BW = 8,
  parameter int CW = 38
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [4:0]    len_m1,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] c,
  output logic          busy,
  output logic          err
);

  localparam int PW = AW + BW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACC   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]    r_state;
  logic [1:0]    w_state_nx;
  logic [4:0]    r_cnt;
  logic [PW-1:0] r_prod;
  logic          r_pvld;
  logic [CW-1:0] r_acc;

  logic          w_idle;
  logic          w_acc;
  logic          w_out;
  logic          w_start;
  logic          w_beat;
  logic          w_last;
  logic          w_done;
  logic [PW-1:0] w_prod;

  assign w_idle  = (r_state == S_IDLE);
  assign w_acc   = (r_state == S_ACC);
  assign w_out   = (r_state == S_OUT);
  assign w_start = w_idle & start;
  assign w_beat  = w_acc & in_valid;
  assign w_last  = w_beat & (r_cnt == 5'd0);
  assign w_done  = w_out & out_ready;
  assign w_prod  = PW'(a) * PW'(b);

  // Next-state decode for the IDLE/ACC/DRAIN/OUT sequence.
  always_comb begin
    w_state_nx = r_state;
    unique case (1'b1)
      w_idle: if (start) w_state_nx = S_ACC;
      w_acc:  if (w_last) w_state_nx = S_DRAIN;
      w_out:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_OUT;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Remaining-term counter: loaded at start, counts down per beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 5'd0;
    end else if (w_start) begin
      r_cnt <= len_m1;
    end else if (w_beat && !w_last) begin
      r_cnt <= r_cnt - 5'd1;
    end
  end

  // Product stage: one registered a*b per accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prod <= '0;
      r_pvld <= 1'b0;
    end else begin
      r_pvld <= w_beat;
      if (w_beat) begin
        r_prod <= w_prod;
      end
    end
  end

  // Accumulate stage: sums any valid product, cleared by a new start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_start) begin
      r_acc <= '0;
    end else if (r_pvld) begin
      r_acc <= r_acc + CW'(r_prod);
    end
  end

`ifdef COEF_MAC38_RANGE_CHK_EN
  localparam logic [AW-1:0] P_MOD = AW'(33550337);

  logic r_err;

  // Sticky flag for any accepted residue at or above p.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_beat && (a >= P_MOD)) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign in_ready  = w_acc;
  assign out_valid = w_out;
  assign busy      = !w_idle;
  assign c         = r_acc;

endmodule
